// File: rtl/decode_stage_reg.sv
// decode_stage_reg: ID/EX boundary register for an RV32I pipeline.
// Picks the per-format immediate from the opcode, classifies the instruction and
// holds it in a main entry plus an optional skid entry. Ready is registered.
module decode_stage_reg #(
  parameter int unsigned PC_WIDTH = 32,
  parameter bit          SKID_EN  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic [31:0]         inst_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [31:0]         i_immed_i,
  input  logic [31:0]         s_immed_i,
  input  logic [31:0]         b_immed_i,
  input  logic [31:0]         u_immed_i,
  input  logic [31:0]         j_immed_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [31:0]         id_inst_o,
  output logic [PC_WIDTH-1:0] id_pc_o,
  output logic [31:0]         id_immed_o,
  output logic [2:0]          id_immed_type_o,
  output logic                id_illegal_o
);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         immed;
    logic [2:0]          itype;
    logic                illegal;
  } entry_t;

  entry_t new_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   deliver;

  // Classify the incoming instruction and pick its immediate at accept time.
  always_comb begin
    new_entry         = '0;
    new_entry.inst    = inst_i;
    new_entry.pc      = pc_i;
    new_entry.immed   = '0;
    new_entry.itype   = IMM_NONE;
    new_entry.illegal = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      new_entry.illegal = 1'b1;
    end else begin
      unique case (inst_i[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
          new_entry.itype = IMM_I;
          new_entry.immed = i_immed_i;
        end
        OPC_STORE: begin
          new_entry.itype = IMM_S;
          new_entry.immed = s_immed_i;
        end
        OPC_BRANCH: begin
          new_entry.itype = IMM_B;
          new_entry.immed = b_immed_i;
        end
        OPC_LUI, OPC_AUIPC: begin
          new_entry.itype = IMM_U;
          new_entry.immed = u_immed_i;
        end
        OPC_JAL: begin
          new_entry.itype = IMM_J;
          new_entry.immed = j_immed_i;
        end
        OPC_OP, OPC_MISC_MEM: begin
          new_entry.itype = IMM_NONE;
        end
        default: begin
          new_entry.illegal = 1'b1;
        end
      endcase
    end
  end

  // With a skid entry, ready depends only on registered state.
  assign inst_ready_o = SKID_EN ? !skid_valid_q : (!main_valid_q || id_ready_i);
  assign accept       = inst_valid_i && inst_ready_o;
  assign deliver      = main_valid_q && id_ready_i;

  // Entry movement: flush wins, then skid refills main, then main or skid load.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (deliver && skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = accept;
      if (accept) skid_d = new_entry;
    end else if (!main_valid_q || deliver) begin
      main_valid_d = accept;
      if (accept) main_d = new_entry;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = new_entry;
    end
    skid_valid_d = skid_valid_d && SKID_EN;
  end

  // Pipeline state; reset clears valids and all visible data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign id_valid_o      = main_valid_q;
  assign id_inst_o       = main_q.inst;
  assign id_pc_o         = main_q.pc;
  assign id_immed_o      = main_q.immed;
  assign id_immed_type_o = main_q.itype;
  assign id_illegal_o    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Self-checking bench for decode_stage_reg: directed scenarios plus a scoreboard
// that tracks accepted instructions against delivered ones.
module tb_decode_stage_reg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] immed;
    logic [2:0]  itype;
    logic        illegal;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic [31:0] i_immed_i, s_immed_i, b_immed_i, u_immed_i, j_immed_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_immed_o;
  logic [2:0]  id_immed_type_o;
  logic        id_illegal_o;

  int tests_run    = 0;
  int tests_failed = 0;

  ent_t exp_q[$];
  ent_t exp_done[$];
  ent_t obs_done[$];

  // Upstream immediate generators, built from the RV32I encodings.
  assign i_immed_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign s_immed_i = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign b_immed_i = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign u_immed_i = {inst_i[31:12], 12'b0};
  assign j_immed_i = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  decode_stage_reg #(.PC_WIDTH(32), .SKID_EN(1'b1)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .inst_valid_i    (inst_valid_i),
    .inst_ready_o    (inst_ready_o),
    .inst_i          (inst_i),
    .pc_i            (pc_i),
    .i_immed_i       (i_immed_i),
    .s_immed_i       (s_immed_i),
    .b_immed_i       (b_immed_i),
    .u_immed_i       (u_immed_i),
    .j_immed_i       (j_immed_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_inst_o       (id_inst_o),
    .id_pc_o         (id_pc_o),
    .id_immed_o      (id_immed_o),
    .id_immed_type_o (id_immed_type_o),
    .id_illegal_o    (id_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    e.inst = ins; e.pc = pc; e.immed = '0; e.itype = 3'd0; e.illegal = 1'b0;
    if (ins[1:0] != 2'b11) e.illegal = 1'b1;
    else begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67, 7'h73: begin e.itype = 3'd1; e.immed = {{20{ins[31]}}, ins[31:20]}; end
        7'h23: begin e.itype = 3'd2; e.immed = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
        7'h63: begin e.itype = 3'd3; e.immed = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
        7'h37, 7'h17: begin e.itype = 3'd4; e.immed = {ins[31:12], 12'b0}; end
        7'h6F: begin e.itype = 3'd5; e.immed = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
        7'h33, 7'h0F: ;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  // One clock: record handshakes at the falling edge, return at posedge+1.
  task automatic tick();
    ent_t x;
    @(negedge clk_i);
    if (rst_ni) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (id_valid_o && id_ready_i) begin
          obs_done.push_back({id_inst_o, id_pc_o, id_immed_o, id_immed_type_o, id_illegal_o});
          if (exp_q.size() > 0) exp_done.push_back(exp_q.pop_front());
          else begin x = 'x; exp_done.push_back(x); end
        end
        if (inst_valid_i && inst_ready_o) exp_q.push_back(model(inst_i, pc_i));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    inst_valid_i = 1'b1;
    inst_i       = ins;
    pc_i         = pc;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; inst_valid_i = 1'b0; inst_i = '0; pc_i = '0; id_ready_i = 1'b0;
    #13;
    tests_run++; if (id_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", id_valid_o); end
    tests_run++; if (inst_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b expected 1", inst_ready_o); end
    tests_run++; if (id_inst_o !== 32'h0) begin tests_failed++; $display("FAIL rst_inst: got %h expected 0", id_inst_o); end
    tests_run++; if (id_pc_o !== 32'h0) begin tests_failed++; $display("FAIL rst_pc: got %h expected 0", id_pc_o); end
    tests_run++; if (id_immed_o !== 32'h0) begin tests_failed++; $display("FAIL rst_immed: got %h expected 0", id_immed_o); end
    tests_run++; if (id_immed_type_o !== 3'd0) begin tests_failed++; $display("FAIL rst_type: got %0d expected 0", id_immed_type_o); end
    tests_run++; if (id_illegal_o !== 1'b0) begin tests_failed++; $display("FAIL rst_illegal: got %b expected 0", id_illegal_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single();
    id_ready_i = 1'b1;
    offer(32'hFFF00093, 32'h100);
    tick();
    inst_valid_i = 1'b0;
    tests_run++; if (id_valid_o !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", id_valid_o); end
    tests_run++; if (id_immed_type_o !== 3'd1) begin tests_failed++; $display("FAIL single_type: got %0d expected 1", id_immed_type_o); end
    tests_run++; if (id_immed_o !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL single_immed: got %h expected ffffffff", id_immed_o); end
    tests_run++; if (id_pc_o !== 32'h100) begin tests_failed++; $display("FAIL single_pc: got %h expected 100", id_pc_o); end
    tests_run++; if (id_illegal_o !== 1'b0) begin tests_failed++; $display("FAIL single_illegal: got %b expected 0", id_illegal_o); end
    tick();
    tests_run++; if (obs_done.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", obs_done.size()); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL single_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_back_to_back();
    id_ready_i = 1'b1;
    offer(32'hFE112E23, 32'h200);
    tick();
    tests_run++; if (id_immed_type_o !== 3'd2 || id_immed_o !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL b2b_sw: got type %0d immed %h expected type 2 immed fffffffc", id_immed_type_o, id_immed_o); end
    offer(32'h123450B7, 32'h204);
    tests_run++; if (inst_ready_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b expected 1", inst_ready_o); end
    tick();
    inst_valid_i = 1'b0;
    tests_run++; if (id_valid_o !== 1'b1 || id_immed_type_o !== 3'd4 || id_immed_o !== 32'h12345000) begin tests_failed++; $display("FAIL b2b_lui: got valid %b type %0d immed %h expected valid 1 type 4 immed 12345000", id_valid_o, id_immed_type_o, id_immed_o); end
    tick();
    tests_run++; if (obs_done.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", obs_done.size()); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL b2b_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_stall();
    logic acc;
    id_ready_i = 1'b0;
    offer(32'h00A00513, 32'h300); tick();
    offer(32'h00B00593, 32'h304); tick();
    offer(32'h00C00613, 32'h308); tick();
    tests_run++; if (inst_ready_o !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: got %b expected 0", inst_ready_o); end
    tests_run++; if (id_inst_o !== 32'h00A00513) begin tests_failed++; $display("FAIL stall_main: got %h expected 00a00513", id_inst_o); end
    id_ready_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = inst_ready_o;
      tick();
    end
    tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL stall_accept_c: got %b expected 1", acc); end
    inst_valid_i = 1'b0;
    for (int i = 0; i < 10 && id_valid_o; i++) tick();
    tests_run++; if (obs_done.size() != 3) begin tests_failed++; $display("FAIL stall_count: got %0d expected 3", obs_done.size()); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL stall_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_illegal();
    id_ready_i = 1'b1;
    offer(32'h00000000, 32'h400); tick();
    tests_run++; if (id_illegal_o !== 1'b1 || id_immed_type_o !== 3'd0 || id_immed_o !== 32'h0) begin tests_failed++; $display("FAIL ill_zero: got ill %b type %0d immed %h expected ill 1 type 0 immed 0", id_illegal_o, id_immed_type_o, id_immed_o); end
    offer(32'h00000033, 32'h404); tick();
    tests_run++; if (id_illegal_o !== 1'b0 || id_immed_type_o !== 3'd0 || id_immed_o !== 32'h0) begin tests_failed++; $display("FAIL ill_add: got ill %b type %0d immed %h expected ill 0 type 0 immed 0", id_illegal_o, id_immed_type_o, id_immed_o); end
    offer(32'h003100B3, 32'h408); tick();
    tests_run++; if (id_illegal_o !== 1'b0 || id_immed_o !== 32'h0) begin tests_failed++; $display("FAIL ill_add_reg: got ill %b immed %h expected ill 0 immed 0", id_illegal_o, id_immed_o); end
    offer(32'hFFF00091, 32'h40C); tick();
    tests_run++; if (id_illegal_o !== 1'b1 || id_immed_o !== 32'h0) begin tests_failed++; $display("FAIL ill_lowbits: got ill %b immed %h expected ill 1 immed 0", id_illegal_o, id_immed_o); end
    inst_valid_i = 1'b0;
    tick();
    tests_run++; if (obs_done.size() != 4) begin tests_failed++; $display("FAIL ill_count: got %0d expected 4", obs_done.size()); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL ill_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_random();
    logic [6:0]  opcs [12];
    logic [31:0] r;
    int          sent;
    opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h5B};
    sent = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom();
      if ($urandom_range(0, 2) != 0) offer({r[31:7], opcs[$urandom_range(0, 11)]}, 32'h1000 + 4 * i);
      else inst_valid_i = 1'b0;
      if ($urandom_range(0, 7) == 0) inst_i[1:0] = r[1:0] & 2'b10;
      id_ready_i = ($urandom_range(0, 2) != 0);
      if (inst_valid_i && inst_ready_o) sent++;
      tick();
    end
    inst_valid_i = 1'b0;
    id_ready_i   = 1'b1;
    for (int i = 0; i < 10 && id_valid_o; i++) tick();
    tests_run++; if (obs_done.size() != sent) begin tests_failed++; $display("FAIL rnd_count: got %0d expected %0d", obs_done.size(), sent); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL rnd_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_flush();
    id_ready_i = 1'b0;
    offer(32'h00100093, 32'h500); tick();
    offer(32'h00200113, 32'h504); tick();
    flush_i = 1'b1;
    offer(32'h00300193, 32'h508); tick();
    flush_i = 1'b0;
    inst_valid_i = 1'b0;
    tests_run++; if (id_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b expected 0", id_valid_o); end
    tests_run++; if (inst_ready_o !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b expected 1", inst_ready_o); end
    id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests_run++; if (obs_done.size() != 0) begin tests_failed++; $display("FAIL flush_count: got %0d expected 0", obs_done.size()); end
    tests_run++; if (id_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_after: got %b expected 0", id_valid_o); end
    obs_done.delete(); exp_done.delete();
  endtask

  task automatic test_reset_mid();
    id_ready_i = 1'b0;
    offer(32'h00400213, 32'h600); tick();
    offer(32'h00500293, 32'h604); tick();
    inst_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    exp_q.delete();
    tests_run++; if (id_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b expected 0", id_valid_o); end
    tests_run++; if (inst_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready: got %b expected 1", inst_ready_o); end
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    id_ready_i = 1'b1;
    offer(32'h00600313, 32'h608); tick();
    inst_valid_i = 1'b0;
    tests_run++; if (id_valid_o !== 1'b1 || id_inst_o !== 32'h00600313) begin tests_failed++; $display("FAIL rmid_first: got valid %b inst %h expected valid 1 inst 00600313", id_valid_o, id_inst_o); end
    tick();
    tests_run++; if (obs_done.size() != 1) begin tests_failed++; $display("FAIL rmid_count: got %0d expected 1", obs_done.size()); end
    for (int k = 0; k < obs_done.size() && k < exp_done.size(); k++) begin
      tests_run++;
      if (obs_done[k] !== exp_done[k]) begin tests_failed++; $display("FAIL rmid_sb[%0d]: got %h expected %h", k, obs_done[k], exp_done[k]); end
    end
    obs_done.delete(); exp_done.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_random();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
